// File: rtl/cpu_pkg.sv
// Shared CPU types plus the instruction-cache additions.
//   memory_address_t : instruction fetch address (CPU PC / ROM address)
//   instruction_t    : one instruction word
//   icache_state_t   : instruction-cache controller states
//   ICACHE_*         : default instruction-cache configuration
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0]  memory_address_t;
    typedef logic [INSTR_WIDTH-1:0] instruction_t;

    localparam int unsigned ICACHE_NUM_LINES = 4;
    localparam int unsigned ICACHE_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StMissWait,
        StRespond
    } icache_state_t;

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the direct-mapped instruction cache: one valid bit, tag and
// instruction per line.
//   clk_i, rst_i            : clock, synchronous active-high reset (valid bits only)
//   flush_i                 : clear every valid bit at the next edge
//   rd_idx_i                : combinational read index
//   rd_valid_o/tag_o/data_o : contents of the indexed line
//   wr_en_i/idx_i/tag_i/data_i : single write port, sets the line valid
module icache_line_store
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_LINES = ICACHE_NUM_LINES,
    parameter int unsigned TAG_WIDTH = ADDR_WIDTH - $clog2(ICACHE_NUM_LINES),
    parameter int unsigned IDX_WIDTH = $clog2(NUM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [IDX_WIDTH-1:0] rd_idx_i,
    output logic                 rd_valid_o,
    output logic [TAG_WIDTH-1:0] rd_tag_o,
    output instruction_t         rd_data_o,
    input  logic                 wr_en_i,
    input  logic [IDX_WIDTH-1:0] wr_idx_i,
    input  logic [TAG_WIDTH-1:0] wr_tag_i,
    input  instruction_t         wr_data_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [NUM_LINES];
    instruction_t         data_q [NUM_LINES];

    // Flush wins over a simultaneous fill so the filled line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instrn_cache.sv
// Direct-mapped, one-instruction-per-line instruction cache between the CPU
// fetch interface and the instruction ROM, with saturating hit/miss counters.
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_instrn_addr, i_instrn_addr_valid : fetch request from the CPU
//   i_instrn_ready                     : CPU can accept an instruction
//   o_instrn, o_instrn_valid           : registered instruction response
//   o_rom_addr, o_rom_req              : single-cycle ROM request on a miss
//   i_rom_data, i_rom_valid            : ROM response (used in MISS_WAIT only)
//   i_flush                            : invalidate all lines
//   o_hit_count, o_miss_count          : saturating performance counters
module instrn_cache
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_LINES = ICACHE_NUM_LINES,
    parameter int unsigned CNT_WIDTH = ICACHE_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  memory_address_t      i_instrn_addr,
    input  logic                 i_instrn_addr_valid,
    input  logic                 i_instrn_ready,
    output instruction_t         o_instrn,
    output logic                 o_instrn_valid,
    output memory_address_t      o_rom_addr,
    output logic                 o_rom_req,
    input  instruction_t         i_rom_data,
    input  logic                 i_rom_valid,
    input  logic                 i_flush,
    output logic [CNT_WIDTH-1:0] o_hit_count,
    output logic [CNT_WIDTH-1:0] o_miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;

    icache_state_t        state_q, state_d;
    memory_address_t      req_addr_q, req_addr_d;
    instruction_t         instrn_q, instrn_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    instruction_t     line_data;
    logic             line_hit;
    logic             fill_en;

    assign req_idx  = req_addr_q[IDX_W-1:0];
    assign req_tag  = req_addr_q[ADDR_WIDTH-1:IDX_W];
    // Uses the registered valid bits, so a flush this cycle cannot alter the decision.
    assign line_hit = line_valid && (line_tag == req_tag);
    assign fill_en  = (state_q == StMissWait) && i_rom_valid;

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .TAG_WIDTH (TAG_W),
        .IDX_WIDTH (IDX_W)
    ) u_line_store (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .flush_i    (i_flush),
        .rd_idx_i   (req_idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (req_idx),
        .wr_tag_i   (req_tag),
        .wr_data_i  (i_rom_data)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        instrn_d   = instrn_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            StIdle: begin
                // Ready gates capture so a stale PC during CPU writeback is ignored.
                if (i_instrn_addr_valid && i_instrn_ready) begin
                    req_addr_d = i_instrn_addr;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (line_hit) begin
                    instrn_d = line_data;
                    if (hit_cnt_q != '1) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                    state_d = StRespond;
                end else begin
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                    state_d = StMissReq;
                end
            end
            StMissReq: begin
                state_d = StMissWait;
            end
            StMissWait: begin
                if (i_rom_valid) begin
                    instrn_d = i_rom_data;
                    state_d  = StRespond;
                end
            end
            StRespond: begin
                if (i_instrn_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            instrn_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            instrn_q   <= instrn_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_instrn       = instrn_q;
    assign o_instrn_valid = (state_q == StRespond);
    assign o_rom_req      = (state_q == StMissReq);
    assign o_rom_addr     = req_addr_q;
    assign o_hit_count    = hit_cnt_q;
    assign o_miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_instrn_cache.sv
// Directed bench for instrn_cache: expected responses go into a scoreboard queue
// at issue time; a negedge monitor pops and compares data and arrival cycle.
module tb_instrn_cache;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    memory_address_t addr;
    logic            addr_valid;
    logic            ready;
    instruction_t    instrn;
    logic            instrn_valid;
    memory_address_t rom_addr;
    logic            rom_req;
    instruction_t    rom_data;
    logic            rom_valid;
    logic            flush;
    logic            flush_main;
    logic            flush_rom;
    logic [15:0]     hit_count;
    logic [15:0]     miss_count;

    assign flush = flush_main | flush_rom;

    instrn_cache dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_instrn_addr       (addr),
        .i_instrn_addr_valid (addr_valid),
        .i_instrn_ready      (ready),
        .o_instrn            (instrn),
        .o_instrn_valid      (instrn_valid),
        .o_rom_addr          (rom_addr),
        .o_rom_req           (rom_req),
        .i_rom_data          (rom_data),
        .i_rom_valid         (rom_valid),
        .i_flush             (flush),
        .o_hit_count         (hit_count),
        .o_miss_count        (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // ROM-model control and request expectations
    int              rom_lat = 2;
    bit              flush_on_fill = 1'b0;
    bit              exp_req_pending = 1'b0;
    memory_address_t exp_req_addr;
    int              exp_req_cyc;
    int              req_count = 0;
    int              exp_hits = 0;
    int              exp_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM model: contents are addr ^ 0xA6 in the low byte.
    initial begin
        memory_address_t a;
        rom_valid = 1'b0;
        rom_data  = '0;
        flush_rom = 1'b0;
        forever begin
            @(negedge clk);
            if (rom_req === 1'b1) begin
                a = rom_addr;
                req_count++;
                check("rom_req_expected", {31'd0, exp_req_pending}, 32'd1);
                check("rom_req_cycle", cyc, exp_req_cyc);
                check("rom_addr", {24'd0, a}, {24'd0, exp_req_addr});
                exp_req_pending = 1'b0;
                repeat (rom_lat) @(posedge clk);
                #1;
                rom_valid = 1'b1;
                rom_data  = {24'd0, a ^ 8'hA6};
                flush_rom = flush_on_fill;
                @(posedge clk);
                #1;
                rom_valid = 1'b0;
                rom_data  = '0;
                flush_rom = 1'b0;
            end
        end
    end

    // Response monitor
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        exp_t e;
        if (instrn_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data %h with nothing outstanding (cycle %0d)",
                         instrn, cyc);
            end else begin
                e = sb.pop_front();
                if (instrn !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response: got %h at cycle %0d expected %h at cycle %0d",
                             instrn, cyc, e.data, e.cyc);
                end
            end
        end
        if (prev_valid === 1'b1 && prev_ready !== 1'b1) begin
            checks++;
            if (instrn_valid !== 1'b1 || instrn !== prev_data) begin
                errors++;
                $display("FAIL hold: got valid=%b data=%h expected valid=1 data=%h",
                         instrn_valid, instrn, prev_data);
            end
        end
        if (prev_valid === 1'b1 && prev_ready === 1'b1) begin
            checks++;
            if (instrn_valid !== 1'b0) begin
                errors++;
                $display("FAIL release: got valid=%b expected 0 after ready", instrn_valid);
            end
        end
        if (prev_req === 1'b1) begin
            checks++;
            if (rom_req !== 1'b0) begin
                errors++;
                $display("FAIL rom_req_pulse: got rom_req=%b expected 0 on second cycle", rom_req);
            end
        end
        prev_valid = instrn_valid;
        prev_ready = ready;
        prev_req   = rom_req;
        prev_data  = instrn;
    end

    task automatic fetch(input memory_address_t a, input logic [31:0] exp_data, input bit miss,
                         input int lat, input int hold, input bit flush_fill);
        int   cap;
        int   req_before;
        exp_t e;
        rom_lat       = lat;
        flush_on_fill = flush_fill;
        req_before    = req_count;
        @(posedge clk);
        #1;
        addr       = a;
        addr_valid = 1'b1;
        ready      = 1'b1;
        @(posedge clk);
        #1;
        cap        = cyc;
        addr_valid = 1'b0;
        ready      = (hold == 0);
        if (miss) begin
            exp_req_addr    = a;
            exp_req_cyc     = cap + 1;
            exp_req_pending = 1'b1;
            exp_misses++;
        end else begin
            exp_hits++;
        end
        e.data = exp_data;
        e.cyc  = miss ? cap + 2 + lat : cap + 1;
        sb.push_back(e);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: no response for addr %h expected %h", a, exp_data);
            sb.delete();
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            ready = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        flush_on_fill = 1'b0;
        check("rom_req_count", req_count - req_before, {31'd0, miss});
        check("hit_count", {16'd0, hit_count}, exp_hits);
        check("miss_count", {16'd0, miss_count}, exp_misses);
    endtask

    initial begin
        int cap;
        rst        = 1'b1;
        addr       = '0;
        addr_valid = 1'b0;
        ready      = 1'b1;
        flush_main = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_instrn", instrn, 32'h0);
        check("reset_instrn_valid", {31'd0, instrn_valid}, 32'd0);
        check("reset_rom_req", {31'd0, rom_req}, 32'd0);
        check("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("reset_hit_count", {16'd0, hit_count}, 32'd0);
        check("reset_miss_count", {16'd0, miss_count}, 32'd0);

        // cold miss then hit
        fetch(8'h05, 32'h0000_00A3, 1'b1, 2, 0, 1'b0);
        fetch(8'h05, 32'h0000_00A3, 1'b0, 2, 0, 1'b0);

        // flush, then conflicting tags on index 1
        @(posedge clk);
        #1;
        flush_main = 1'b1;
        @(posedge clk);
        #1;
        flush_main = 1'b0;
        fetch(8'h05, 32'h0000_00A3, 1'b1, 3, 0, 1'b0);
        fetch(8'h09, 32'h0000_00AF, 1'b1, 1, 0, 1'b0);
        fetch(8'h05, 32'h0000_00A3, 1'b1, 2, 0, 1'b0);

        // CPU stalls for 3 cycles in RESPOND
        fetch(8'h05, 32'h0000_00A3, 1'b0, 2, 3, 1'b0);

        // flush lands with the fill: data returned, line left invalid
        fetch(8'h02, 32'h0000_00A4, 1'b1, 2, 0, 1'b1);
        fetch(8'h02, 32'h0000_00A4, 1'b1, 1, 0, 1'b0);

        // reset during MISS_WAIT abandons the miss
        rom_lat = 4;
        @(posedge clk);
        #1;
        addr       = 8'h0A;
        addr_valid = 1'b1;
        @(posedge clk);
        #1;
        cap             = cyc;
        addr_valid      = 1'b0;
        exp_req_addr    = 8'h0A;
        exp_req_cyc     = cap + 1;
        exp_req_pending = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        check("post_rst_hit_count", {16'd0, hit_count}, 32'd0);
        check("post_rst_miss_count", {16'd0, miss_count}, 32'd0);
        check("post_rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("post_rst_instrn", instrn, 32'h0);
        check("post_rst_valid", {31'd0, instrn_valid}, 32'd0);
        fetch(8'h0A, 32'h0000_00AC, 1'b1, 2, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
